c_bus_writeback: RTL and testbench
==================================

Name: c_bus_writeback

Overview:
- Write-side counterpart of the B-bus source selector: captures the C bus (ALU result) into the selected datapath register on the clock edge.
- Holds the register set PC, MDR, MAR, IR, GP and GP2, and drives all of them continuously to the B-bus selector.
- Also owns the PC auto-increment, the memory-to-MDR load path and the Z flag register.

Parameters:
- DATA_W, 16, width of the C bus and of every register.
- RESET_PC, 16'h0000, PC value after reset.
- PC_STEP, 1, increment applied by pc_inc.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- C_bus  in  DATA_W  ALU result to write back.
- C_sel  in  3  destination select: 000 none, 001 GP, 010 PC, 011 GP2, 100 MDR, 101 MAR, 110 IR, 111 none.
- pc_inc  in  1  increment PC by PC_STEP this cycle.
- mem_data  in  DATA_W  read data from memory.
- mem_valid  in  1  load mem_data into MDR this cycle.
- z_en  in  1  update Z from this cycle's C-bus write.
- PC, MDR, MAR, IR, GP, GP2  out  DATA_W each  registered values; feed the B-bus selector.
- Z  out  1  zero flag.
- wr_conflict  out  1  sticky flag: a same-cycle conflict occurred.

Behaviour:
- Reset (rst_n=0 at an edge): PC=RESET_PC; MDR, MAR, IR, GP and GP2 = 0; Z=0; wr_conflict=0. Reset overrides every other input in that cycle.
- Write latency: a C_sel write made at edge N is visible on the output from edge N onward, one cycle after the inputs were presented. There is no combinational path from inputs to outputs.
- Only the selected register changes; all other registers hold.
- C_sel 000 and 111 write nothing.
- PC update priority, per cycle:
  - C_sel=010 loads C_bus.
  - Else pc_inc loads PC+PC_STEP, modulo 2^DATA_W; 16'hFFFF + 1 wraps to 16'h0000.
  - Else PC holds.
- MDR update priority:
  - C_sel=100 loads C_bus.
  - Else mem_valid loads mem_data.
  - Else MDR holds.
- Conflicts: wr_conflict sets when (C_sel=010 and pc_inc) or (C_sel=100 and mem_valid). It stays set until reset.
- Z flag:
  - When z_en=1 and C_sel is a valid destination (001..110), Z <= (C_bus == 0).
  - z_en with C_sel 000 or 111 also sets Z <= (C_bus == 0); this allows a flag-only ALU operation.
  - z_en=0: Z holds.
  - Z never reflects pc_inc or mem_valid loads.
- X handling: C_sel X/Z is treated as no write, and the simulation model flags an assertion.
- Reset in the middle of a sequence: any write or increment presented in the reset cycle is discarded; the next cycle starts from reset values.

Decomposition:
- Shared package (bus_pkg) holds:
  - DATA_W
  - the 3-bit register-select localparams SEL_NONE0, SEL_GP, SEL_PC, SEL_GP2, SEL_MDR, SEL_MAR, SEL_IR, SEL_NONE7, used by both this block and the B-bus selector so the encodings cannot drift.
- One natural sub-module: pc_counter (load, increment, wrap, reset value). All other registers are inline.

Test Plan:
- Reset: rst_n=0 for 2 cycles with C_sel=001, C_bus=16'h1234 → after release PC=RESET_PC, every other register 0, Z=0, wr_conflict=0.
- Per-select write: for each C_sel 001..110, drive C_bus=16'hA5A0+sel for one cycle → only that register equals the value one edge later. C_sel=000 and 111 change nothing.
- PC wrap: load PC=16'hFFFE via C_sel=010, then pc_inc for 3 cycles → PC reads FFFF, 0000, 0001.
- Collision: C_sel=010, C_bus=16'h0040 with pc_inc=1; separately C_sel=100, C_bus=16'h0007 with mem_valid=1, mem_data=16'hBEEF → PC=0040, MDR=0007, wr_conflict=1 and held until reset.
- Z flag:
  - C_sel=001, C_bus=0, z_en=1 → Z=1.
  - Next cycle C_bus=16'h0001, z_en=0 → Z stays 1.
  - Then C_sel=000, C_bus=16'h0003, z_en=1 → Z=0.
- Mid-operation reset: pc_inc=1 and mem_valid=1 in the same cycle as rst_n=0 → PC=RESET_PC, MDR=0.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared datapath width and register-select encodings for the
//               B-bus selector and the C-bus writeback block.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] SEL_NONE0 = 3'b000;
    localparam logic [2:0] SEL_GP    = 3'b001;
    localparam logic [2:0] SEL_PC    = 3'b010;
    localparam logic [2:0] SEL_GP2   = 3'b011;
    localparam logic [2:0] SEL_MDR   = 3'b100;
    localparam logic [2:0] SEL_MAR   = 3'b101;
    localparam logic [2:0] SEL_IR    = 3'b110;
    localparam logic [2:0] SEL_NONE7 = 3'b111;

endpackage
`default_nettype wire

// File: rtl/c_bus_writeback_pc_counter.sv
`default_nettype none
// ============================================================================
// Module      : c_bus_writeback_pc_counter
// Description : Program counter with load, wrapping increment and reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module c_bus_writeback_pc_counter #(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] PC_STEP  = DATA_W'(1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [DATA_W-1:0] pc_o
);

    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_d;

    // A load always beats an increment; the add wraps at the register width.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/c_bus_writeback.sv
`default_nettype none
// ============================================================================
// Module      : c_bus_writeback
// Description : Captures the C bus into the selected datapath register and
//               owns PC increment, memory-to-MDR load and the Z flag.
// Revision    : 1.0 - initial release
// ============================================================================
module c_bus_writeback #(
    parameter int                DATA_W   = bus_pkg::DATA_W,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] PC_STEP  = DATA_W'(1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] C_bus,
    input  logic [2:0]        C_sel,
    input  logic              pc_inc,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_valid,
    input  logic              z_en,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] MDR,
    output logic [DATA_W-1:0] MAR,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] GP,
    output logic [DATA_W-1:0] GP2,
    output logic              Z,
    output logic              wr_conflict
);

    import bus_pkg::*;

    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] mar_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] gp_q;
    logic [DATA_W-1:0] gp2_q;
    logic              z_q;
    logic              conflict_q;

    logic w_wr_gp;
    logic w_wr_pc;
    logic w_wr_gp2;
    logic w_wr_mdr;
    logic w_wr_mar;
    logic w_wr_ir;
    logic w_conflict;

    // An unknown select matches no item and therefore writes nothing.
    always_comb begin
        w_wr_gp  = 1'b0;
        w_wr_pc  = 1'b0;
        w_wr_gp2 = 1'b0;
        w_wr_mdr = 1'b0;
        w_wr_mar = 1'b0;
        w_wr_ir  = 1'b0;
        case (C_sel)
            SEL_GP:               w_wr_gp  = 1'b1;
            SEL_PC:               w_wr_pc  = 1'b1;
            SEL_GP2:              w_wr_gp2 = 1'b1;
            SEL_MDR:              w_wr_mdr = 1'b1;
            SEL_MAR:              w_wr_mar = 1'b1;
            SEL_IR:               w_wr_ir  = 1'b1;
            SEL_NONE0, SEL_NONE7: ;
            default:              ;
        endcase
    end

    assign w_conflict = (w_wr_pc & pc_inc) | (w_wr_mdr & mem_valid);

    c_bus_writeback_pc_counter #(
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_wr_pc),
        .load_val_i (C_bus),
        .inc_i      (pc_inc),
        .pc_o       (PC)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mdr_q      <= '0;
            mar_q      <= '0;
            ir_q       <= '0;
            gp_q       <= '0;
            gp2_q      <= '0;
            z_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            if (w_wr_gp)  gp_q  <= C_bus;
            if (w_wr_gp2) gp2_q <= C_bus;
            if (w_wr_mar) mar_q <= C_bus;
            if (w_wr_ir)  ir_q  <= C_bus;
            if (w_wr_mdr) begin
                mdr_q <= C_bus;
            end else if (mem_valid) begin
                mdr_q <= mem_data;
            end
            // Z follows the C bus even with no destination, for flag-only ops.
            if (z_en) z_q <= (C_bus == '0);
            if (w_conflict) conflict_q <= 1'b1;
        end
    end

    a_csel_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(C_sel));

    assign MDR         = mdr_q;
    assign MAR         = mar_q;
    assign IR          = ir_q;
    assign GP          = gp_q;
    assign GP2         = gp2_q;
    assign Z           = z_q;
    assign wr_conflict = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_c_bus_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_c_bus_writeback
// Description : Directed self-checking bench for c_bus_writeback with an
//               array-based register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_c_bus_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] C_bus;
    logic [2:0]  C_sel;
    logic        pc_inc;
    logic [15:0] mem_data;
    logic        mem_valid;
    logic        z_en;
    logic [15:0] PC, MDR, MAR, IR, GP, GP2;
    logic        Z;
    logic        wr_conflict;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    // Model: one slot per select code; slot 2 is PC, slot 4 is MDR.
    logic [15:0] m_r [0:7];
    logic        m_z;
    logic        m_conf;

    c_bus_writeback dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .C_bus       (C_bus),
        .C_sel       (C_sel),
        .pc_inc      (pc_inc),
        .mem_data    (mem_data),
        .mem_valid   (mem_valid),
        .z_en        (z_en),
        .PC          (PC),
        .MDR         (MDR),
        .MAR         (MAR),
        .IR          (IR),
        .GP          (GP),
        .GP2         (GP2),
        .Z           (Z),
        .wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        logic [15:0] nxt [0:7];
        nxt = m_r;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) nxt[i] = 16'h0000;
            m_z    = 1'b0;
            m_conf = 1'b0;
        end else begin
            if (C_sel >= 3'd1 && C_sel <= 3'd6) nxt[C_sel] = C_bus;
            if (C_sel != 3'd2 && pc_inc)    nxt[2] = m_r[2] + 16'd1;
            if (C_sel != 3'd4 && mem_valid) nxt[4] = mem_data;
            if ((C_sel == 3'd2 && pc_inc) || (C_sel == 3'd4 && mem_valid)) m_conf = 1'b1;
            if (z_en) m_z = (C_bus == 16'h0000);
        end
        m_r = nxt;
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("PC",   PC,   m_r[2]);
            chk("GP",   GP,   m_r[1]);
            chk("GP2",  GP2,  m_r[3]);
            chk("MDR",  MDR,  m_r[4]);
            chk("MAR",  MAR,  m_r[5]);
            chk("IR",   IR,   m_r[6]);
            chk("Z",    {15'd0, Z},           {15'd0, m_z});
            chk("CONF", {15'd0, wr_conflict}, {15'd0, m_conf});
        end
    end

    task automatic cyc(input logic r, input logic [2:0] s, input logic [15:0] b,
                       input logic inc, input logic mv, input logic [15:0] md,
                       input logic ze);
        rst_n = r; C_sel = s; C_bus = b; pc_inc = inc;
        mem_valid = mv; mem_data = md; z_en = ze;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(1'b0, 3'd1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0);
        check_en = 1'b1;
        cyc(1'b0, 3'd1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("rst_PC",   PC,  16'h0000);
        chk("rst_GP",   GP,  16'h0000);
        chk("rst_Z",    {15'd0, Z}, 16'h0000);
        chk("rst_CONF", {15'd0, wr_conflict}, 16'h0000);

        for (int s = 0; s < 8; s++) begin
            cyc(1'b1, 3'(s), 16'hA5A0 + 16'(s), 1'b0, 1'b0, 16'h0000, 1'b0);
        end
        chk("sel_GP",  GP,  16'hA5A1);
        chk("sel_PC",  PC,  16'hA5A2);
        chk("sel_GP2", GP2, 16'hA5A3);
        chk("sel_MDR", MDR, 16'hA5A4);
        chk("sel_MAR", MAR, 16'hA5A5);
        chk("sel_IR",  IR,  16'hA5A6);

        cyc(1'b1, 3'd2, 16'hFFFE, 1'b0, 1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("wrap1", PC, 16'hFFFF);
        cyc(1'b1, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("wrap2", PC, 16'h0000);
        cyc(1'b1, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("wrap3", PC, 16'h0001);

        cyc(1'b1, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h1357, 1'b0);
        chk("memld", MDR, 16'h1357);
        chk("noconf", {15'd0, wr_conflict}, 16'h0000);
        cyc(1'b1, 3'd2, 16'h0040, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("colPC",  PC, 16'h0040);
        chk("colC1",  {15'd0, wr_conflict}, 16'h0001);
        cyc(1'b1, 3'd4, 16'h0007, 1'b0, 1'b1, 16'hBEEF, 1'b0);
        chk("colMDR", MDR, 16'h0007);
        cyc(1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("colHold", {15'd0, wr_conflict}, 16'h0001);

        cyc(1'b1, 3'd1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("Z1", {15'd0, Z}, 16'h0001);
        cyc(1'b1, 3'd1, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("Zhold", {15'd0, Z}, 16'h0001);
        chk("Zgp",   GP, 16'h0001);
        cyc(1'b1, 3'd0, 16'h0003, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("Z0", {15'd0, Z}, 16'h0000);
        cyc(1'b1, 3'd7, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1);
        chk("Z7", {15'd0, Z}, 16'h0001);
        chk("pcInc", PC, 16'h0041);

        cyc(1'b0, 3'd5, 16'h7777, 1'b1, 1'b1, 16'hFFFF, 1'b1);
        chk("mrPC",   PC,  16'h0000);
        chk("mrMDR",  MDR, 16'h0000);
        chk("mrCONF", {15'd0, wr_conflict}, 16'h0000);
        cyc(1'b1, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("postPC", PC, 16'h0001);
        cyc(1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
